// File: rtl/hwregs_bus_arbiter_if.sv
// Register-bus channel: a requester drives a command, the responder returns ack and read data.
interface hwregs_bus_arbiter_if;
    logic        request;
    logic [15:0] addr;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output request, addr, write, byte_enable, wdata,
        input  rdata, ack
    );

    modport slave (
        input  request, addr, write, byte_enable, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/hwregs_bus_arbiter.sv
// Shares the hardware-register bus between m0 (CPU) and m1 (debug/DMA): one-deep slot per
// master, round-robin issue of one transaction at a time, watchdog-forced completion.
module hwregs_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    hwregs_bus_arbiter_if.slave  m0,
    hwregs_bus_arbiter_if.slave  m1,
    hwregs_bus_arbiter_if.master hw,
    output logic                 bus_timeout
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
    } cmd_t;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  pend_q, pend_d;
    cmd_t        slot_q [2];
    cmd_t        slot_d [2];
    cmd_t        hw_cmd_q, hw_cmd_d;
    logic        hw_request_q, hw_request_d;
    logic [1:0]  ack_q, ack_d;
    logic [31:0] rdata_q [2];
    logic [31:0] rdata_d [2];
    logic        bus_timeout_q, bus_timeout_d;

    logic [1:0]  req_in;
    cmd_t        cmd_in [2];
    logic [1:0]  accept;
    logic        pick;

    assign req_in    = {m1.request, m0.request};
    assign cmd_in[0] = {m0.addr, m0.write, m0.byte_enable, m0.wdata};
    assign cmd_in[1] = {m1.addr, m1.write, m1.byte_enable, m1.wdata};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        slot_d        = slot_q;
        hw_cmd_d      = hw_cmd_q;
        hw_request_d  = 1'b0;
        ack_d         = '0;
        rdata_d       = '{default: '0};
        bus_timeout_d = 1'b0;
        accept        = '0;
        // With a single pending slot pend_q[1] names it; a tie goes to the master not served last.
        pick          = pend_q[1];

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    if (&pend_q) begin
                        pick = ~last_grant_q;
                    end
                    grant_d      = pick;
                    last_grant_d = pick;
                    hw_request_d = 1'b1;
                    hw_cmd_d     = slot_q[pick];
                    pend_d[pick] = 1'b0;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hw.ack) begin
                    ack_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = hw.rdata;
                    state_d          = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = 32'hFFFF_FFFF;
                    bus_timeout_d    = 1'b1;
                    state_d          = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request into a full slot, or from the master that owns WAIT, is dropped.
        for (int i = 0; i < 2; i++) begin
            accept[i] = req_in[i] && !pend_q[i] && !(state_q == ST_WAIT && grant_q == 1'(i));
            if (accept[i]) begin
                pend_d[i] = 1'b1;
                slot_d[i] = cmd_in[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            pend_q        <= '0;
            hw_cmd_q      <= '0;
            hw_request_q  <= 1'b0;
            ack_q         <= '0;
            rdata_q       <= '{default: '0};
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            hw_cmd_q      <= hw_cmd_d;
            hw_request_q  <= hw_request_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    // NOTE: slot payload storage has no reset; pend_q alone says whether a slot holds anything.
    always_ff @(posedge clock) begin
        slot_q <= slot_d;
    end

    assign m0.ack         = ack_q[0];
    assign m0.rdata       = rdata_q[0];
    assign m1.ack         = ack_q[1];
    assign m1.rdata       = rdata_q[1];
    assign hw.request     = hw_request_q;
    assign hw.addr        = hw_cmd_q.addr;
    assign hw.write       = hw_cmd_q.write;
    assign hw.byte_enable = hw_cmd_q.byte_enable;
    assign hw.wdata       = hw_cmd_q.wdata;
    assign bus_timeout    = bus_timeout_q;

endmodule

// File: tb/tb_hwregs_bus_arbiter.sv
// Bench for hwregs_bus_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model (issue times, owners, completion times and data from the bus rules).
module tb_hwregs_bus_arbiter;

    localparam int TO    = 16;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic bus_timeout;

    hwregs_bus_arbiter_if m0_if ();
    hwregs_bus_arbiter_if m1_if ();
    hwregs_bus_arbiter_if hw_if ();

    hwregs_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .m0         (m0_if),
        .m1         (m1_if),
        .hw         (hw_if),
        .bus_timeout(bus_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    bit          waiting [2];
    int          ready [2];
    txn_t        slot [2];
    txn_t        hold;
    bit          busy;
    int          owner;
    int          resp_delay;
    logic [31:0] resp_data;
    int          pending_ack_cyc;
    int          done_cyc;
    logic [31:0] done_data;
    bit          done_to;
    int          free_cyc;
    int          last;
    bit          done_now [2];
    int          completions [2];
    int          last_issue_cyc [2];
    int          issue_log [$];

    // Responder knobs
    int          force_delay = -1;
    bit          use_force_data = 0;
    logic [31:0] force_data = '0;
    bit          spurious_en = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic [15:0] a, input logic w, input logic [3:0] be,
                                input logic [31:0] d);
        txn_t t;
        t.addr = a; t.write = w; t.be = be; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        return mk(16'($urandom()), 1'($urandom()), 4'($urandom()), $urandom());
    endfunction

    function automatic int rand_delay();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return $urandom_range(1, 5);
            6:                return TO - 1;
            7:                return TO;
            8:                return NEVER;
            default:          return $urandom_range(1, TO - 1);
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        m0_if.request = 1'b0;            m1_if.request = 1'b0;
        m0_if.addr    = 16'($urandom()); m1_if.addr    = 16'($urandom());
        m0_if.write   = 1'($urandom());  m1_if.write   = 1'($urandom());
        m0_if.byte_enable = 4'($urandom()); m1_if.byte_enable = 4'($urandom());
        m0_if.wdata   = $urandom();      m1_if.wdata   = $urandom();
        hw_if.ack     = 1'b0;
        hw_if.rdata   = $urandom();
    endtask

    task automatic req(input int m, input txn_t t);
        if (m == 0) begin
            m0_if.request = 1'b1; m0_if.addr = t.addr; m0_if.write = t.write;
            m0_if.byte_enable = t.be; m0_if.wdata = t.wdata;
        end else begin
            m1_if.request = 1'b1; m1_if.addr = t.addr; m1_if.write = t.write;
            m1_if.byte_enable = t.be; m1_if.wdata = t.wdata;
        end
        if (!waiting[m] && !(busy && owner == m)) begin
            waiting[m] = 1'b1;
            ready[m]   = cyc + 2;
            slot[m]    = t;
        end
    endtask

    task automatic model_step();
        bit          exp_ack [2];
        logic [31:0] exp_rd [2];
        bit          exp_to;
        bit          rdy0, rdy1;
        int          pick;
        exp_ack[0] = 0; exp_ack[1] = 0;
        exp_rd[0]  = '0; exp_rd[1] = '0;
        exp_to     = 0;
        done_now[0] = 0; done_now[1] = 0;
        if (busy && cyc == done_cyc) begin
            exp_ack[owner] = 1;
            exp_rd[owner]  = done_data;
            exp_to         = done_to;
            busy           = 0;
            free_cyc       = cyc + 1;
            done_now[owner] = 1;
            completions[owner]++;
        end
        check("m0_ack", 32'(m0_if.ack), 32'(exp_ack[0]));
        check("m0_rdata", m0_if.rdata, exp_rd[0]);
        check("m1_ack", 32'(m1_if.ack), 32'(exp_ack[1]));
        check("m1_rdata", m1_if.rdata, exp_rd[1]);
        check("bus_timeout", 32'(bus_timeout), 32'(exp_to));

        pick = -1;
        rdy0 = waiting[0] && (ready[0] <= cyc);
        rdy1 = waiting[1] && (ready[1] <= cyc);
        if (!busy && cyc >= free_cyc) begin
            if (rdy0 && rdy1) pick = 1 - last;
            else if (rdy0)    pick = 0;
            else if (rdy1)    pick = 1;
        end
        if (pick >= 0) begin
            hold          = slot[pick];
            waiting[pick] = 0;
            last          = pick;
            busy          = 1;
            owner         = pick;
            last_issue_cyc[pick] = cyc;
            issue_log.push_back(pick);
            resp_delay = (force_delay >= 0) ? force_delay : rand_delay();
            resp_data  = use_force_data ? force_data : $urandom();
            pending_ack_cyc = (resp_delay <= TO) ? cyc + resp_delay : -1;
            if (resp_delay < TO) begin
                done_cyc = cyc + resp_delay + 1; done_data = resp_data; done_to = 0;
            end else begin
                done_cyc = cyc + TO; done_data = 32'hFFFF_FFFF; done_to = 1;
            end
        end
        check("hw_request", 32'(hw_if.request), 32'(pick >= 0));
        check("hw_addr", 32'(hw_if.addr), 32'(hold.addr));
        check("hw_write", 32'(hw_if.write), 32'(hold.write));
        check("hw_be", 32'(hw_if.byte_enable), 32'(hold.be));
        check("hw_wdata", hw_if.wdata, hold.wdata);

        if (cyc == pending_ack_cyc) begin
            hw_if.ack = 1'b1; hw_if.rdata = resp_data;
        end else if (spurious_en && !busy && $urandom_range(0, 7) == 0) begin
            hw_if.ack = 1'b1; hw_if.rdata = $urandom();
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            model_step();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m0_ack"}, 32'(m0_if.ack), 32'd0);
        check({tag, "_m0_rdata"}, m0_if.rdata, 32'd0);
        check({tag, "_m1_ack"}, 32'(m1_if.ack), 32'd0);
        check({tag, "_m1_rdata"}, m1_if.rdata, 32'd0);
        check({tag, "_hw_req"}, 32'(hw_if.request), 32'd0);
        check({tag, "_hw_addr"}, 32'(hw_if.addr), 32'd0);
        check({tag, "_hw_write"}, 32'(hw_if.write), 32'd0);
        check({tag, "_hw_be"}, 32'(hw_if.byte_enable), 32'd0);
        check({tag, "_hw_wdata"}, hw_if.wdata, 32'd0);
        check({tag, "_timeout"}, 32'(bus_timeout), 32'd0);
    endtask

    task automatic model_reset();
        waiting[0] = 0; waiting[1] = 0;
        busy = 0; owner = 0; last = 1;
        pending_ack_cyc = -1; done_cyc = -1;
        free_cyc = cyc;
        hold = '0;
    endtask

    // Asserts reset between clock edges, checks outputs clear at once, releases two cycles later.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int t0, c0, n1, m1_count;
        bit m1_sent;

        m0_if.request = 0; m0_if.addr = 0; m0_if.write = 0; m0_if.byte_enable = 0; m0_if.wdata = 0;
        m1_if.request = 0; m1_if.addr = 0; m1_if.write = 0; m1_if.byte_enable = 0; m1_if.wdata = 0;
        hw_if.ack = 0; hw_if.rdata = 0;
        completions[0] = 0; completions[1] = 0;
        last_issue_cyc[0] = 0; last_issue_cyc[1] = 0;
        reset = 1'b1;
        tick();
        tick();
        check_outputs_zero("rst_init");
        reset = 1'b0;
        model_reset();

        // 1: single m0 read, exact latency
        force_delay = 1; use_force_data = 1; force_data = 32'h0000_03FF;
        req(0, mk(16'h0008, 1'b0, 4'hF, 32'h0));
        run(1);
        check("t1_no_req_early", 32'(hw_if.request), 32'd0);
        run(1);
        check("t1_hw_req", 32'(hw_if.request), 32'd1);
        check("t1_hw_addr", 32'(hw_if.addr), 32'h0008);
        check("t1_hw_write", 32'(hw_if.write), 32'd0);
        run(1);
        check("t1_no_ack_early", 32'(m0_if.ack), 32'd0);
        run(1);
        check("t1_m0_ack", 32'(m0_if.ack), 32'd1);
        check("t1_m0_rdata", m0_if.rdata, 32'h0000_03FF);
        run(2);

        // 2: tie after reset goes to m0; a later tie after m0 was served goes to m1
        use_force_data = 0;
        apply_reset();
        req(0, mk(16'h0024, 1'b0, 4'hF, 32'h0));
        req(1, mk(16'h0028, 1'b0, 4'hF, 32'h0));
        t0 = issue_log.size();
        run(8);
        check("t2_first", 32'((issue_log.size() > t0) ? issue_log[t0] : -1), 32'd0);
        check("t2_second", 32'((issue_log.size() > t0 + 1) ? issue_log[t0 + 1] : -1), 32'd1);
        check("t2_gap", 32'(last_issue_cyc[1] - last_issue_cyc[0]), 32'd3);
        req(0, rand_txn());
        run(6);
        req(0, rand_txn());
        req(1, rand_txn());
        t0 = issue_log.size();
        run(8);
        check("t2_repeat_first", 32'((issue_log.size() > t0) ? issue_log[t0] : -1), 32'd1);

        // 3: m1 write, fields forwarded exactly
        force_delay = 2; use_force_data = 1; force_data = 32'hA5A5_0001;
        req(1, mk(16'h0004, 1'b1, 4'b0011, 32'h1234_5678));
        run(2);
        check("t3_hw_addr", 32'(hw_if.addr), 32'h0004);
        check("t3_hw_write", 32'(hw_if.write), 32'd1);
        check("t3_hw_be", 32'(hw_if.byte_enable), 32'h3);
        check("t3_hw_wdata", hw_if.wdata, 32'h1234_5678);
        run(2);
        check("t3_m1_ack_pre", 32'(m1_if.ack), 32'd0);
        run(1);
        check("t3_m1_ack", 32'(m1_if.ack), 32'd1);
        check("t3_m1_rdata", m1_if.rdata, 32'hA5A5_0001);
        check("t3_m0_quiet", 32'(m0_if.ack) | m0_if.rdata, 32'd0);
        run(2);

        // 4: watchdog, late ack ignored, never-acked, then normal transaction
        force_delay = TO; use_force_data = 0;
        req(1, rand_txn());
        run(2);
        run(TO - 1);
        check("t4_ack_pre", 32'(m1_if.ack), 32'd0);
        check("t4_to_pre", 32'(bus_timeout), 32'd0);
        run(1);
        check("t4_ack", 32'(m1_if.ack), 32'd1);
        check("t4_rdata", m1_if.rdata, 32'hFFFF_FFFF);
        check("t4_timeout", 32'(bus_timeout), 32'd1);
        run(2);
        check("t4_late_ignored", 32'(m1_if.ack), 32'd0);
        force_delay = NEVER;
        req(0, rand_txn());
        run(TO + 2);
        check("t4_never_ack", 32'(m0_if.ack), 32'd1);
        check("t4_never_to", 32'(bus_timeout), 32'd1);
        force_delay = 3; use_force_data = 1; force_data = 32'hCAFE_F00D;
        req(1, rand_txn());
        run(6);
        check("t4_next_ack", 32'(m1_if.ack), 32'd1);
        check("t4_next_rdata", m1_if.rdata, 32'hCAFE_F00D);
        run(2);

        // 5: reset in the middle of WAIT
        force_delay = NEVER; use_force_data = 0;
        req(0, rand_txn());
        run(4);
        apply_reset();
        run(TO + 4);
        force_delay = 1; use_force_data = 1; force_data = 32'h0000_5A5A;
        req(0, rand_txn());
        run(3);
        check("t5_ack_pre", 32'(m0_if.ack), 32'd0);
        run(1);
        check("t5_ack", 32'(m0_if.ack), 32'd1);
        check("t5_rdata", m0_if.rdata, 32'h0000_5A5A);
        run(2);

        // 6: m0 back-to-back for 20 transactions, m1 injects one request
        force_delay = 2; use_force_data = 0;
        c0 = completions[0]; m1_sent = 0; n1 = 0;
        req(0, rand_txn());
        for (int k = 0; k < 400 && (completions[0] - c0) < 20; k++) begin
            tick();
            model_step();
            if (done_now[0] && (completions[0] - c0) < 20) req(0, rand_txn());
            if (!m1_sent && busy && owner == 0 && (completions[0] - c0) >= 5) begin
                n1 = issue_log.size();
                req(1, rand_txn());
                m1_sent = 1;
            end
        end
        run(8);
        check("t6_m0_count", 32'(completions[0] - c0), 32'd20);
        check("t6_m1_next", 32'((m1_sent && issue_log.size() > n1) ? issue_log[n1] : -1), 32'd1);
        m1_count = 0;
        for (int i = n1; i < issue_log.size(); i++) m1_count += issue_log[i];
        check("t6_m1_once", 32'(m1_count), 32'd1);

        // Random traffic, including requests into busy slots and spurious acks in IDLE
        force_delay = -1; use_force_data = 0; spurious_en = 1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            model_step();
            if ($urandom_range(0, 3) == 0) req(0, rand_txn());
            if ($urandom_range(0, 3) == 0) req(1, rand_txn());
        end
        spurious_en = 0;
        run(3 * TO);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
